// File: rtl/blake2_compress_ctrl.sv
// Iterative BLAKE2 compression sequencer: one G step per clock over the 16-word working
// vector, R rounds of 4 column + 4 diagonal steps, with the sigma message schedule.
module blake2_compress_ctrl #(
    parameter int W = 64,
    parameter int R = 12
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            start_i,
    input  logic [16*W-1:0] v_i,
    input  logic [16*W-1:0] m_i,
    output logic            ready_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [16*W-1:0] v_o
);
    localparam int RW   = (R > 1) ? $clog2(R) : 1;
    localparam int ROT1 = (W == 64) ? 32 : 16;
    localparam int ROT2 = (W == 64) ? 24 : 12;
    localparam int ROT3 = (W == 64) ? 16 : 8;
    localparam int ROT4 = (W == 64) ? 63 : 7;

    // Each row packs the 16 sigma entries with element 0 in the top nibble.
    localparam logic [63:0] SIGMA [10] = '{
        64'h0123456789ABCDEF,
        64'hEA489FD61C02B753,
        64'hB8C052FDAE367194,
        64'h7931DCBE265A40F8,
        64'h905724AFE1BC683D,
        64'h2C6A0B834D75FE19,
        64'hC51FED4A0763928B,
        64'hDB7EC13950F4862A,
        64'h6FE9B308C2D714A5,
        64'hA2847615FBE93CD0
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  v [16];
    logic [W-1:0]  m [16];
    logic [RW-1:0] r;
    logic [2:0]    j;
    int            rnum;
    logic [3:0]    row;
    logic [63:0]   sig_row;
    logic [5:0]    xsel, ysel;
    logic [3:0]    ia, ib, ic, id;
    logic [W-1:0]  x, y;
    logic [W-1:0]  a1, b1, c1, d1, a2, b2, c2, d2;
    logic          last_step;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] val, input int n);
        return (val >> n) | (val << (W - n));
    endfunction

    // Diagonal steps rotate the b/c/d lanes by 1/2/3 within their row of four.
    always_comb begin
        rnum    = int'(r);
        row     = (rnum >= 10) ? 4'(rnum - 10) : 4'(rnum);
        sig_row = SIGMA[row];
        xsel    = 6'd60 - {j, 3'b000};
        ysel    = 6'd56 - {j, 3'b000};
        x       = m[sig_row[xsel +: 4]];
        y       = m[sig_row[ysel +: 4]];
        ia      = {2'b00, j[1:0]};
        ib      = {2'b01, j[1:0] + {1'b0, j[2]}};
        ic      = {2'b10, j[1:0] + {j[2], 1'b0}};
        id      = {2'b11, j[1:0] + {j[2], j[2]}};
    end

    always_comb begin
        a1 = v[ia] + v[ib] + x;
        d1 = rotr(v[id] ^ a1, ROT1);
        c1 = v[ic] + d1;
        b1 = rotr(v[ib] ^ c1, ROT2);
        a2 = a1 + b1 + y;
        d2 = rotr(d1 ^ a2, ROT3);
        c2 = c1 + d2;
        b2 = rotr(b1 ^ c2, ROT4);
    end

    assign last_step = (state == RUN) && (r == RW'(R - 1)) && (j == 3'd7);

    always_comb begin
        state_nx = state;
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) state_nx = RUN;
            end
            RUN: begin
                if (last_step) state_nx = DONE;
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            r     <= '0;
            j     <= '0;
            for (int k = 0; k < 16; k++) begin
                v[k] <= '0;
                m[k] <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == IDLE && start_i) begin
                for (int k = 0; k < 16; k++) begin
                    v[k] <= v_i[k*W +: W];
                    m[k] <= m_i[k*W +: W];
                end
                r <= '0;
                j <= '0;
            end else if (state == RUN) begin
                v[ia] <= a2;
                v[ib] <= b2;
                v[ic] <= c2;
                v[id] <= d2;
                j     <= j + 3'd1;
                if (j == 3'd7) r <= r + RW'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 16; k++) v_o[k*W +: W] = v[k];
    end
endmodule

// File: tb/tb_blake2_compress_ctrl.sv
// Self-checking bench for blake2_compress_ctrl: BLAKE2b and BLAKE2s instances checked
// against RFC 7693 vectors and a round-level reference model of the compression.
module tb_blake2_compress_ctrl;
    typedef logic [15:0][63:0] pvec_t;
    typedef logic [7:0][63:0]  hvec_t;
    typedef struct {
        int    sel;
        hvec_t h;
        pvec_t vin;
        pvec_t m;
        hvec_t hexp;
    } rec_t;

    localparam int SIGMA_TAB [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11, 14,  9,  3, 12, 13,  0}
    };
    localparam int G_IDX [8][4] = '{
        '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
    };
    localparam logic [63:0] IV64 [8] = '{
        64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
        64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179
    };
    localparam logic [31:0] IV32 [8] = '{
        32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
        32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
    };

    logic          clk, nreset;
    logic          b_start, b_ack, b_rdy, b_vld;
    logic [1023:0] b_vi, b_mi, b_vo;
    logic          s_start, s_ack, s_rdy, s_vld;
    logic [511:0]  s_vi, s_mi, s_vo;
    int            checks = 0;
    int            failures = 0;
    rec_t          tbl [6];

    blake2_compress_ctrl #(.W(64), .R(12)) dut_b (
        .clk(clk), .nreset(nreset), .start_i(b_start), .v_i(b_vi), .m_i(b_mi),
        .ready_o(b_rdy), .valid_o(b_vld), .ready_i(b_ack), .v_o(b_vo)
    );
    blake2_compress_ctrl #(.W(32), .R(10)) dut_s (
        .clk(clk), .nreset(nreset), .start_i(s_start), .v_i(s_vi), .m_i(s_mi),
        .ready_o(s_rdy), .valid_o(s_vld), .ready_i(s_ack), .v_o(s_vo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int sel);
        return (sel == 0) ? 64 : 32;
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rand_word(input int w);
        return {$urandom, $urandom} & mask_of(w);
    endfunction

    function automatic logic [63:0] rotr_m(input logic [63:0] val, input int n, input int w);
        logic [63:0] t;
        t = val & mask_of(w);
        return ((t >> n) | (t << (w - n))) & mask_of(w);
    endfunction

    // Whole compression straight from the round/step description, one G per step.
    function automatic pvec_t model_compress(input int w, input pvec_t vin, input pvec_t m);
        pvec_t       v;
        logic [63:0] mk, x, y;
        int          rot [4];
        int          a, b, c, d, rounds;
        mk     = mask_of(w);
        rounds = (w == 64) ? 12 : 10;
        if (w == 64) rot = '{32, 24, 16, 63};
        else         rot = '{16, 12, 8, 7};
        v = vin;
        for (int rd = 0; rd < rounds; rd++) begin
            for (int st = 0; st < 8; st++) begin
                a = G_IDX[st][0]; b = G_IDX[st][1]; c = G_IDX[st][2]; d = G_IDX[st][3];
                x = m[SIGMA_TAB[rd % 10][2*st]];
                y = m[SIGMA_TAB[rd % 10][2*st+1]];
                v[a] = (v[a] + v[b] + x) & mk;
                v[d] = rotr_m(v[d] ^ v[a], rot[0], w);
                v[c] = (v[c] + v[d]) & mk;
                v[b] = rotr_m(v[b] ^ v[c], rot[1], w);
                v[a] = (v[a] + v[b] + y) & mk;
                v[d] = rotr_m(v[d] ^ v[a], rot[2], w);
                v[c] = (v[c] + v[d]) & mk;
                v[b] = rotr_m(v[b] ^ v[c], rot[3], w);
            end
        end
        return v;
    endfunction

    task automatic build_rfc(input int w, output hvec_t h, output pvec_t vin, output pvec_t m);
        logic [63:0] iv;
        for (int i = 0; i < 8; i++) begin
            iv         = (w == 64) ? IV64[i] : {32'h0, IV32[i]};
            h[i]       = iv;
            vin[8 + i] = iv;
        end
        h[0] = h[0] ^ ((w == 64) ? 64'h0000_0000_0101_0040 : 64'h0000_0000_0101_0020);
        for (int i = 0; i < 8; i++) vin[i] = h[i];
        vin[12] = vin[12] ^ 64'd3;
        vin[14] = ~vin[14] & mask_of(w);
        m       = '0;
        m[0]    = 64'h0000_0000_0063_6261;
    endtask

    function automatic logic [63:0] dut_word(input int sel, input int k);
        return (sel == 0) ? b_vo[k*64 +: 64] : {32'h0, s_vo[k*32 +: 32]};
    endfunction

    function automatic logic dut_ready(input int sel);
        return (sel == 0) ? b_rdy : s_rdy;
    endfunction

    function automatic logic dut_valid(input int sel);
        return (sel == 0) ? b_vld : s_vld;
    endfunction

    task automatic set_start(input int sel, input logic val);
        if (sel == 0) b_start = val; else s_start = val;
    endtask

    task automatic set_ack(input int sel, input logic val);
        if (sel == 0) b_ack = val; else s_ack = val;
    endtask

    task automatic drive_block(input int sel, input pvec_t vin, input pvec_t m);
        if (sel == 0) begin
            b_vi = vin;
            b_mi = m;
        end else begin
            for (int k = 0; k < 16; k++) begin
                s_vi[k*32 +: 32] = vin[k][31:0];
                s_mi[k*32 +: 32] = m[k][31:0];
            end
        end
    endtask

    task automatic drive_garbage();
        for (int k = 0; k < 32; k++) begin
            b_vi[k*32 +: 32] = $urandom;
            b_mi[k*32 +: 32] = $urandom;
        end
        for (int k = 0; k < 16; k++) begin
            s_vi[k*32 +: 32] = $urandom;
            s_mi[k*32 +: 32] = $urandom;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic random_block(input int w, output pvec_t vin, output pvec_t m);
        for (int k = 0; k < 16; k++) begin
            vin[k] = rand_word(w);
            m[k]   = rand_word(w);
        end
    endtask

    // Runs one table record: accept, latency, feed-forward result, handshake.
    task automatic applyStimulus(input int idx);
        rec_t        rec;
        int          edges;
        logic [63:0] hact;
        rec = tbl[idx];
        @(negedge clk);
        drive_block(rec.sel, rec.vin, rec.m);
        set_ack(rec.sel, 1'b0);
        set_start(rec.sel, 1'b1);
        checkOutput($sformatf("ready_idle tbl%0d", idx), dut_ready(rec.sel), 64'd1);
        @(negedge clk);
        set_start(rec.sel, 1'b0);
        drive_garbage();
        checkOutput($sformatf("ready_drop tbl%0d", idx), dut_ready(rec.sel), 64'd0);
        edges = 0;
        while (!dut_valid(rec.sel) && edges < 300) begin
            @(negedge clk);
            edges++;
        end
        checkOutput($sformatf("latency tbl%0d", idx), edges, (rec.sel == 0) ? 64'd96 : 64'd80);
        for (int i = 0; i < 8; i++) begin
            hact = rec.h[i] ^ dut_word(rec.sel, i) ^ dut_word(rec.sel, i + 8);
            checkOutput($sformatf("hprime[%0d] tbl%0d", i, idx), hact, rec.hexp[i]);
        end
        set_ack(rec.sel, 1'b1);
        @(negedge clk);
        set_ack(rec.sel, 1'b0);
        checkOutput($sformatf("valid_fall tbl%0d", idx), dut_valid(rec.sel), 64'd0);
        checkOutput($sformatf("ready_rise tbl%0d", idx), dut_ready(rec.sel), 64'd1);
    endtask

    task automatic backpressure(input int sel);
        pvec_t       vin, m, exp;
        logic [63:0] snap [16];
        int          cyc, drops, changes, w;
        w = width_of(sel);
        random_block(w, vin, m);
        exp = model_compress(w, vin, m);
        @(negedge clk);
        drive_block(sel, vin, m);
        set_ack(sel, 1'b0);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        cyc = 0;
        while (!dut_valid(sel) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 16; k++) snap[k] = dut_word(sel, k);
        drops   = 0;
        changes = 0;
        for (int c = 0; c < 20; c++) begin
            set_start(sel, (c % 4) == 1);
            @(negedge clk);
            if (!dut_valid(sel) || dut_ready(sel)) drops++;
            for (int k = 0; k < 16; k++) if (dut_word(sel, k) !== snap[k]) changes++;
        end
        checkOutput("bp_valid_held", drops, 64'd0);
        checkOutput("bp_vo_stable", changes, 64'd0);
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("bp_vo[%0d]", k), dut_word(sel, k), exp[k]);
        set_start(sel, 1'b0);
        set_ack(sel, 1'b1);
        @(negedge clk);
        set_ack(sel, 1'b0);
        checkOutput("bp_valid_fall", dut_valid(sel), 64'd0);
        checkOutput("bp_ready_rise", dut_ready(sel), 64'd1);
        @(negedge clk);
        checkOutput("bp_start_not_queued", dut_ready(sel), 64'd1);
    endtask

    task automatic back_to_back(input int sel);
        pvec_t vin [2];
        pvec_t m [2];
        pvec_t exp [2];
        int    accepts, valids, busy, gap, cyc, w;
        logic  start_now;
        w = width_of(sel);
        for (int i = 0; i < 2; i++) begin
            random_block(w, vin[i], m[i]);
            exp[i] = model_compress(w, vin[i], m[i]);
        end
        accepts = 0; valids = 0; busy = 0; gap = -1; cyc = 0;
        @(negedge clk);
        drive_block(sel, vin[0], m[0]);
        set_ack(sel, 1'b1);
        set_start(sel, 1'b1);
        start_now = 1'b1;
        while (valids < 2 && cyc < 600) begin
            if (dut_valid(sel)) begin
                for (int k = 0; k < 16; k++)
                    checkOutput($sformatf("b2b_blk%0d_vo[%0d]", valids, k), dut_word(sel, k), exp[valids][k]);
                valids++;
            end
            if (dut_ready(sel)) begin
                if (start_now) begin
                    accepts++;
                    if (accepts == 2) gap = busy;
                end
            end else if (accepts == 1) begin
                busy++;
            end
            @(negedge clk);
            cyc++;
            if (accepts == 1) drive_block(sel, vin[1], m[1]);
            if (accepts >= 2) begin
                set_start(sel, 1'b0);
                start_now = 1'b0;
            end
        end
        checkOutput("b2b_results", valids, 64'd2);
        checkOutput("b2b_busy_cycles", gap, (sel == 0) ? 64'd97 : 64'd81);
        @(negedge clk);
        set_ack(sel, 1'b0);
        checkOutput("b2b_idle", dut_ready(sel), 64'd1);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        drive_block(0, tbl[0].vin, tbl[0].m);
        set_ack(0, 1'b0);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (37) @(negedge clk);
        checkOutput("mid_running", b_rdy | b_vld, 64'd0);
        nreset = 1'b0;
        #1;
        checkOutput("mid_rst_ready", b_rdy, 64'd1);
        checkOutput("mid_rst_valid", b_vld, 64'd0);
        checkOutput("mid_rst_vo_zero", |b_vo, 64'd0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        hvec_t h;
        pvec_t vin, m, vout;
        int    w;
        nreset  = 1'b0;
        b_start = 1'b1;
        s_start = 1'b1;
        b_ack   = 1'b0;
        s_ack   = 1'b0;
        drive_garbage();

        build_rfc(64, h, vin, m);
        tbl[0].sel = 0; tbl[0].h = h; tbl[0].vin = vin; tbl[0].m = m;
        tbl[0].hexp = {64'h239900D4ED8623B9, 64'h5A92F1DBA88AD318, 64'h95CC3345DED552C2,
                       64'h2D79AB2A39C5877D, 64'hD1A2FFDB6FBB124B, 64'hB7C45A68142F214C,
                       64'hE9F6129FB697276A, 64'h0D4D1C983FA580BA};
        build_rfc(32, h, vin, m);
        tbl[1].sel = 1; tbl[1].h = h; tbl[1].vin = vin; tbl[1].m = m;
        tbl[1].hexp = {64'h82596786, 64'h4C9B994D, 64'h293AD69E, 64'h208B4537,
                       64'h2F45EB4E, 64'hA32BA7E1, 64'hE2147C32, 64'h8C5E8C50};
        for (int i = 2; i < 6; i++) begin
            tbl[i].sel = i % 2;
            w = width_of(tbl[i].sel);
            random_block(w, vin, m);
            for (int k = 0; k < 8; k++) h[k] = rand_word(w);
            vout = model_compress(w, vin, m);
            tbl[i].h = h; tbl[i].vin = vin; tbl[i].m = m;
            for (int k = 0; k < 8; k++) tbl[i].hexp[k] = h[k] ^ vout[k] ^ vout[k + 8];
        end

        repeat (3) @(negedge clk);
        checkOutput("rst_ready_b", b_rdy, 64'd1);
        checkOutput("rst_valid_b", b_vld, 64'd0);
        checkOutput("rst_vo_b", |b_vo, 64'd0);
        checkOutput("rst_ready_s", s_rdy, 64'd1);
        checkOutput("rst_valid_s", s_vld, 64'd0);
        checkOutput("rst_vo_s", |s_vo, 64'd0);
        nreset = 1'b1;
        #1;
        checkOutput("release_ready_b", b_rdy, 64'd1);
        b_start = 1'b0;
        s_start = 1'b0;
        @(negedge clk);
        checkOutput("no_spurious_b", b_rdy, 64'd1);
        checkOutput("no_spurious_s", s_rdy, 64'd1);

        for (int i = 0; i < 6; i++) applyStimulus(i);
        backpressure(1);
        back_to_back(0);
        mid_reset();
        applyStimulus(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/blake2_compress_ctrl.md
# blake2_compress_ctrl

Iterative BLAKE2 compression sequencer. It owns the 16-word working vector `v` and drives a single combinational G-function instance, one G step per clock: R rounds × 8 steps (4 column, then 4 diagonal). It applies the sigma message schedule to select `x`/`y` each step. It sits between the hash front end, which builds `v` from `h`, IV, counter and final flag, and the feed-forward stage `h' = h ^ v[0..7] ^ v[8..15]`, which stays outside this block.

## Interface
Parameters:
- `W`, 64, word width; only 64 (BLAKE2b) and 32 (BLAKE2s) are legal.
- `R`, 12, round count; 12 for W=64, 10 for W=32.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `nreset`  in  1  asynchronous active-low reset.
- `start_i`  in  1  request to start a compression; sampled only while `ready_o`=1.
- `v_i`  in  16*W  initial working vector; word k is at `[k*W +: W]`.
- `m_i`  in  16*W  message block; same packing. Captured at accept.
- `ready_o`  out  1  block is idle and can accept `start_i`.
- `valid_o`  out  1  `v_o` holds the final working vector.
- `ready_i`  in  1  downstream consumed `v_o`.
- `v_o`  out  16*W  working-vector register, same packing.

## Operation
- Internal G rotation constants:
  - W=64: R1..R4 = 32, 24, 16, 63.
  - W=32: R1..R4 = 16, 12, 8, 7.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE: `ready_o`=1. If `start_i`=1, load `v`←`v_i` and `m`←`m_i`, clear round counter `r` and step counter `j`, go to RUN.
  - RUN: apply step j of round r:
    - G indices (a,b,c,d) for j=0..7: (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15), (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
    - `x` = m[σ[r mod 10][2j]], `y` = m[σ[r mod 10][2j+1]], with σ the standard BLAKE2 10×16 permutation table held internally as a constant.
    - Write G outputs back to v[a], v[b], v[c], v[d] on the same edge.
    - Increment j. When j wraps from 7 to 0, increment r.
    - After the step with r=R-1, j=7, go to DONE.
  - DONE: `valid_o`=1 and `v_o` stays stable. When `ready_i`=1, go to IDLE.
- `start_i` outside IDLE is ignored. It is not queued.
- The `m` register is read-only during RUN. `v_i` and `m_i` may change freely after the accept edge.
- All additions are mod 2^W and carries are discarded. `r` is ⌈log2 R⌉ bits. σ row index = r mod 10, so rounds 10 and 11 reuse rows 0 and 1.
- `v_o` is the `v` register at all times. Its contents are meaningful only while `valid_o`=1.

## Timing
- Reset values: state IDLE, `ready_o`=1, `valid_o`=0, `v`=0, `m`=0, r=0, j=0.
- Accept happens on an edge where `start_i` and `ready_o` are both 1. `ready_o` drops on that edge.
- Exactly 8·R RUN edges follow the accept edge. `valid_o` rises on the edge that writes the last G step: 96 edges for BLAKE2b, 80 for BLAKE2s.
- The handshake completes on an edge where `valid_o` and `ready_i` are both 1.
  - `valid_o` falls and `ready_o` rises on that same edge.
  - The next accept is possible on the following edge, so minimum accept-to-accept spacing is 8·R+1 cycles.
- `ready_i` held at 1 before `valid_o` rises gives a 1-cycle DONE.
- `nreset` asserted in any state immediately forces all reset values. An in-flight compression is discarded with no partial `valid_o`.
- The G path is single-cycle combinational, so the critical path is two 3-way adds plus two 2-input adds. No pipelining.

## Test plan
- Reset: hold `nreset`=0 with `start_i`=1 → `ready_o`=1, `valid_o`=0, `v_o`=0. After release, no spurious accept before the first sampled edge.
- BLAKE2b "abc" (W=64, R=12):
  - Stimulus: RFC 7693 Appendix A `v_i` and `m_i`; m[0]=0x0000000000636261, others 0; counter 3, final flag set.
  - Required: `valid_o` exactly 96 edges after accept; bench feed-forward h'[0]=0x0D4D1C983FA580BA and all 8 words match the RFC.
- BLAKE2s "abc" (W=32, R=10): RFC 7693 Appendix B vectors → `valid_o` at 80 edges; h'[0]=0x8C5E8C50.
- Backpressure: hold `ready_i`=0 for 20 cycles after `valid_o` → `v_o` stable and `valid_o` held. Pulse `start_i` during DONE → ignored. Raise `ready_i` → IDLE on that edge.
- Back-to-back: two random blocks, `ready_i`=1, `start_i` asserted continuously → accepts 8·R+1 cycles apart; both results match the reference model.
- Mid-operation reset: assert `nreset` at step 37 → outputs at reset values. A subsequent "abc" run → correct result, proving no residual state.
